// File: rtl/bus_register_bank_if.sv
// bus_register_bank_if: command and status signals between the microcode sequencer and the register bank
//   sel           register select (shared by load, output and op)
//   load          active-low load of reg[sel] from the data bus
//   enable_output drive reg[sel] onto the data bus
//   op            in-place unary operation on reg[sel]
//   regs          flattened register contents, reg[i] at [i*WIDTH +: WIDTH]
//   zero_flag     last written value was zero
//   carry_flag    carry/borrow/shifted-out bit of the last op
//   op_dropped    one-cycle pulse when an op lost to a simultaneous load
interface bus_register_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEL_W = $clog2(DEPTH)
);
    logic [SEL_W-1:0]       sel;
    logic                   load;
    logic                   enable_output;
    logic [2:0]             op;
    logic [WIDTH*DEPTH-1:0] regs;
    logic                   zero_flag;
    logic                   carry_flag;
    logic                   op_dropped;
    modport master (
        output sel, load, enable_output, op,
        input  regs, zero_flag, carry_flag, op_dropped
    );
    modport slave (
        input  sel, load, enable_output, op,
        output regs, zero_flag, carry_flag, op_dropped
    );
endinterface

// File: rtl/bus_register_bank.sv
// bus_register_bank: register bank on the shared tri-state CPU data bus with in-place unary ops and flags
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   shared tri-state data bus
//   bif   command/status interface (slave side)
module bus_register_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    inout  wire  [WIDTH-1:0]       bus,
    bus_register_bank_if.slave     bif
);
    logic [DEPTH-1:0][WIDTH-1:0] r_regs;
    logic                        r_zero;
    logic                        r_carry;
    logic                        r_drop;
    logic                        w_valid;
    logic [WIDTH-1:0]            w_cur;
    logic [WIDTH-1:0]            w_res;
    logic                        w_carry;
    // out-of-range selects read as zero and never write
    assign w_valid = int'(bif.sel) < DEPTH;
    assign w_cur   = w_valid ? r_regs[bif.sel] : '0;
    // bus is released during reset regardless of enable_output
    assign bus = (rst_n && bif.enable_output) ? w_cur : 'z;
    always_comb begin
        w_res   = w_cur;
        w_carry = r_carry;
        case (bif.op)
            3'b001: {w_carry, w_res} = '0;
            3'b010: {w_carry, w_res} = {1'b0, w_cur} + (WIDTH+1)'(1);
            3'b011: {w_carry, w_res} = {w_cur == '0, w_cur - WIDTH'(1)};
            3'b100: {w_carry, w_res} = {w_cur[WIDTH-1], w_cur[WIDTH-2:0], 1'b0};
            3'b101: {w_carry, w_res} = {w_cur[0], 1'b0, w_cur[WIDTH-1:1]};
            3'b110: {w_carry, w_res} = {w_cur[WIDTH-1], w_cur[WIDTH-2:0], w_cur[WIDTH-1]};
            3'b111: {w_carry, w_res} = {w_cur[0], w_cur[0], w_cur[WIDTH-1:1]};
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs  <= '0;
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_valid) begin
                if (!bif.load) begin
                    r_regs[bif.sel] <= bus;
                    r_zero          <= bus == '0;
                    r_carry         <= 1'b0;
                    r_drop          <= bif.op != 3'b000;
                end else if (bif.op != 3'b000) begin
                    r_regs[bif.sel] <= w_res;
                    r_zero          <= w_res == '0;
                    r_carry         <= w_carry;
                end
            end
        end
    end
    assign bif.regs       = r_regs;
    assign bif.zero_flag  = r_zero;
    assign bif.carry_flag = r_carry;
    assign bif.op_dropped = r_drop;
endmodule

// File: tb/tb_bus_register_bank.sv
// tb_bus_register_bank: randomized self-checking bench against an arithmetic reference model
module tb_bus_register_bank;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_val = '0;
    tri1  [7:0] bus;
    int         n_checks = 0;
    int         n_errors = 0;
    int         m_reg [4];
    int         m_z, m_c, m_d;
    bus_register_bank_if #(.WIDTH(8), .DEPTH(4)) bif ();
    bus_register_bank #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .bif   (bif.slave)
    );
    assign bus = tb_drv ? tb_val : 'z;
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        m_z = 1; m_c = 0; m_d = 0;
    endtask
    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s reg%0d", tag, i), int'(bif.regs[i*8 +: 8]), m_reg[i]);
        check({tag, " zero"}, int'(bif.zero_flag), m_z);
        check({tag, " carry"}, int'(bif.carry_flag), m_c);
        check({tag, " drop"}, int'(bif.op_dropped), m_d);
    endtask
    task automatic step(input int s, input bit ld_n, input bit en, input int o, input bit drv, input int v);
        int r, res, c, bv;
        bif.sel = 2'(s); bif.load = ld_n; bif.enable_output = en; bif.op = 3'(o);
        tb_drv = drv; tb_val = 8'(v);
        #1;
        if (en && !drv) check("bus pre", int'(bus), m_reg[s]);
        bv = drv ? v : (en ? m_reg[s] : 255);
        @(posedge clk);
        r = m_reg[s];
        if (!ld_n) begin
            m_reg[s] = bv; m_z = int'(bv == 0); m_c = 0; m_d = int'(o != 0);
        end else begin
            m_d = 0;
            if (o != 0) begin
                case (o)
                    1: begin res = 0;                       c = 0;       end
                    2: begin res = (r + 1) % 256;           c = r / 255; end
                    3: begin res = (r + 255) % 256;         c = int'(r == 0); end
                    4: begin res = (r * 2) % 256;           c = r / 128; end
                    5: begin res = r / 2;                   c = r % 2;   end
                    6: begin res = (r * 2) % 256 + r / 128; c = r / 128; end
                    default: begin res = r / 2 + (r % 2) * 128; c = r % 2; end
                endcase
                m_reg[s] = res; m_z = int'(res == 0); m_c = c;
            end
        end
        #1;
        check_all($sformatf("op%0d sel%0d", o, s));
        if (en && !drv) check("bus post", int'(bus), m_reg[s]);
        tb_drv = 1'b0;
    endtask
    initial begin
        int s, o, v;
        bit ld_n, en;
        bif.sel = '0; bif.load = 1'b1; bif.enable_output = 1'b0; bif.op = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk) rst_n = 1'b1;
        step(2, 0, 0, 0, 1, 8'hA5);
        check("load A5", int'(bif.regs[23:16]), 8'hA5);
        check("load zero", int'(bif.zero_flag), 0);
        step(2, 1, 1, 0, 0, 0);
        check("out sel2", int'(bus), 8'hA5);
        step(1, 1, 1, 0, 0, 0);
        check("out sel1", int'(bus), 8'h00);
        step(0, 0, 0, 0, 1, 8'hFF);
        step(0, 1, 0, 2, 0, 0);
        check("inc wrap c", int'(bif.carry_flag), 1);
        check("inc wrap z", int'(bif.zero_flag), 1);
        step(0, 1, 0, 3, 0, 0);
        check("dec wrap v", int'(bif.regs[7:0]), 8'hFF);
        check("dec wrap c", int'(bif.carry_flag), 1);
        for (int k = 4; k < 8; k++) begin
            step(3, 0, 0, 0, 1, 8'h81);
            step(3, 1, 1, k, 0, 0);
        end
        check("ror 81", int'(bif.regs[31:24]), 8'hC0);
        step(1, 0, 0, 2, 1, 8'h10);
        check("prio val", int'(bif.regs[15:8]), 8'h10);
        check("prio drop", int'(bif.op_dropped), 1);
        step(1, 1, 0, 0, 0, 0);
        check("drop pulse", int'(bif.op_dropped), 0);
        step(2, 0, 1, 0, 0, 0);
        check("self reload", int'(bif.regs[23:16]), 8'hA5);
        bif.sel = 2'd2; bif.enable_output = 1'b1; bif.load = 1'b1; bif.op = '0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async rst");
        check("rst bus z", int'(bus), 8'hFF);
        @(negedge clk) rst_n = 1'b1;
        bif.enable_output = 1'b0;
        for (int n = 0; n < 400; n++) begin
            s = $urandom_range(0, 3);
            o = $urandom_range(0, 7);
            ld_n = $urandom_range(0, 3) != 0;
            case ($urandom_range(0, 5))
                0: v = 8'h00;
                1: v = 8'hFF;
                2: v = 8'h80;
                3: v = 8'h01;
                default: v = $urandom_range(0, 255);
            endcase
            en = $urandom_range(0, 2) == 0;
            step(s, ld_n, en, o, !ld_n && !en, v);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bus_register_bank.md
# bus_register_bank

Parametrised bank of general-purpose registers that sits on the shared tri-state CPU data bus alongside the accumulator. The microcode sequencer addresses it with a select field. A selected register can be loaded from the bus, driven onto the bus, or modified in place by a single-cycle unary operation. Zero and carry flags are produced for the control unit's conditional jumps.

## Interface
Parameters:
- WIDTH, 8, register and bus width in bits (≥2)
- DEPTH, 4, number of registers (≥2)
- SEL_W, $clog2(DEPTH), select field width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- bus  inout  WIDTH  shared data bus
- sel  in  SEL_W  register addressed by load, output and op
- load  in  1  active-low; when 0, reg[sel] <= bus at the clock edge
- enable_output  in  1  active-high; when 1, reg[sel] is driven onto the bus; otherwise the bus is high-Z
- op  in  3  in-place operation on reg[sel]:
  - 000 none
  - 001 clear
  - 010 increment
  - 011 decrement
  - 100 shift left
  - 101 shift right (logical)
  - 110 rotate left
  - 111 rotate right
- regs  out  WIDTH*DEPTH  flattened register contents; reg[i] occupies bits [i*WIDTH +: WIDTH]
- zero_flag  out  1  registered; 1 when the last written value was 0
- carry_flag  out  1  registered carry, borrow or shifted-out bit of the last op
- op_dropped  out  1  registered one-cycle pulse: an op was ignored because load was active

## Operation
- Reset (rst_n = 0, asynchronous):
  - all registers 0
  - zero_flag = 1, carry_flag = 0, op_dropped = 0
  - the bus is released (high-Z) while rst_n = 0, regardless of enable_output
- Bus drive is combinational: bus = enable_output ? reg[sel] : {WIDTH{Z}}.
- Write priority at each edge, for reg[sel] only; other registers hold:
  1. load = 0: reg[sel] <= bus.
     - zero_flag <= (bus == 0); carry_flag <= 0.
     - If op ≠ 000, the op is ignored and op_dropped <= 1.
  2. else op ≠ 000: reg[sel] <= result.
     - zero_flag <= (result == 0); carry_flag is set per op (below).
  3. else: no change; flags hold; op_dropped <= 0.
- Per-op results and carry:
  - clear: result 0; carry 0.
  - increment: result (r+1) mod 2^WIDTH; carry 1 only when r = all-ones (wrap to 0).
  - decrement: result (r−1) mod 2^WIDTH; carry (borrow) 1 only when r = 0 (wrap to all-ones).
  - shift left: {r[WIDTH−2:0],0}; carry r[WIDTH−1].
  - shift right: {0,r[WIDTH−1:1]}; carry r[0].
  - rotate left: {r[WIDTH−2:0],r[WIDTH−1]}; carry r[WIDTH−1].
  - rotate right: {r[0],r[WIDTH−1:1]}; carry r[0].
- Simultaneous enable_output = 1 and load = 0 on the same sel: the register reloads its own value. This is legal: the register is unchanged, zero_flag is updated from that value, and carry_flag is cleared.
- enable_output = 1 with op ≠ 000: the bus shows the pre-op value until the edge and the post-op value after it.
- sel ≥ DEPTH (only possible when DEPTH is not a power of two):
  - load and op are ignored; flags hold; op_dropped <= 0.
  - When enable_output = 1, the bus is driven with 0.
- No internal state machine beyond the registers and flags. Every operation completes in one cycle.

## Timing
- Load and op latency: 1 cycle. The new value is visible on regs and the bus (if enabled) after the capturing edge.
- Flags and op_dropped update on the same edge as the register write.
- bus, sel and load must be stable around the rising edge. The bus source must be valid in the same cycle load is asserted.
- No back-pressure or handshake. A new command is accepted every cycle.
- rst_n assertion takes effect immediately. Deassertion is assumed synchronous to clk externally; the first write can occur at the first edge after deassertion.

## Test plan
- Reset: pulse rst_n low mid-cycle after loading data.
  - Required: all regs 0 immediately, zero_flag=1, carry_flag=0, bus high-Z.
- Load and output, WIDTH=8, DEPTH=4:
  - load=0, sel=2, bus=0xA5 → reg[2]=0xA5 next cycle, others 0, zero_flag=0.
  - Then enable_output=1, sel=2 → bus reads 0xA5.
  - sel=1 → bus reads 0x00.
- Increment wrap: reg[0]=0xFF, op=010 → reg[0]=0x00, zero_flag=1, carry_flag=1.
- Decrement wrap: reg[0]=0x00, op=011 → reg[0]=0xFF, zero_flag=0, carry_flag=1.
- Shifts and rotates on reg[3]=0x81:
  - op=100 → 0x02, carry 1.
  - op=101 → 0x40, carry 1.
  - op=110 → 0x03, carry 1.
  - op=111 → 0xC0, carry 1.
- Priority: load=0, bus=0x10, op=010, sel=1 in the same cycle.
  - Required: reg[1]=0x10 (no increment), op_dropped=1 for exactly one cycle, carry_flag=0.
